// File: rtl/rgb2bayer_mosaic.sv
// Streaming RGB-to-Bayer re-mosaicer: one raw CFA sample per valid pixel, chosen by
// row/column parity and the configured CFA phase, with line-length and frame-height checks.
module rgb2bayer_mosaic #(
  parameter int DATA_WIDTH    = 8,
  parameter int I_W           = 1922,
  parameter int I_H           = 1082,
  parameter int BAYER_PATTERN = 0
) (
  input  logic                  I_Clk,
  input  logic                  I_Rst,
  input  logic                  I_V_Sync,
  input  logic                  I_H_Sync,
  input  logic                  I_RGB_Vaild,
  input  logic [DATA_WIDTH-1:0] I_RGB_Data_r,
  input  logic [DATA_WIDTH-1:0] I_RGB_Data_g,
  input  logic [DATA_WIDTH-1:0] I_RGB_Data_b,
  output logic                  O_V_Sync,
  output logic                  O_H_Sync,
  output logic                  O_Raw_Vaild,
  output logic [DATA_WIDTH-1:0] O_Raw_Data,
  output logic                  O_Line_Err,
  output logic                  O_Frame_Err
);

  localparam int CW = $clog2(I_W + 1);
  localparam int RW = $clog2(I_H + 1);
  localparam logic [CW-1:0] COL_MAX = {CW{1'b1}};
  localparam logic [RW-1:0] ROW_MAX = {RW{1'b1}};
  localparam logic [CW-1:0] COL_LEN = CW'(I_W);
  localparam logic [RW-1:0] ROW_LEN = RW'(I_H);
  localparam logic [1:0]    PHASE   = 2'(BAYER_PATTERN);

  logic                  v_d;
  logic                  vaild_d;
  logic [CW-1:0]         col_cnt;
  logic [RW-1:0]         row_cnt;
  logic                  v_rise;
  logic                  line_end;
  logic [CW-1:0]         pix_col;
  logic [RW-1:0]         pix_row;
  logic [CW-1:0]         col_next;
  logic [RW-1:0]         row_next;
  logic [DATA_WIDTH-1:0] raw_next;
  logic                  line_err_next;
  logic                  frame_err_next;

  // (r,c) parity after phase adjustment: 00 -> R, 11 -> B, mixed -> G
  function automatic logic [DATA_WIDTH-1:0] select_sample(
    input logic                  r_par,
    input logic                  c_par,
    input logic [DATA_WIDTH-1:0] r,
    input logic [DATA_WIDTH-1:0] g,
    input logic [DATA_WIDTH-1:0] b
  );
    logic [DATA_WIDTH-1:0] s;
    case ({r_par, c_par})
      2'b00:   s = r;
      2'b01:   s = g;
      2'b10:   s = g;
      2'b11:   s = b;
      default: s = g;
    endcase
    return s;
  endfunction

  // Edge detection, pixel position, counter update and error detection
  always_comb begin
    v_rise   = I_V_Sync & ~v_d;
    line_end = vaild_d & ~I_RGB_Vaild;

    // A V_Sync rise forces the coincident pixel to position (0,0)
    if (v_rise) begin
      pix_row = {RW{1'b0}};
      pix_col = {CW{1'b0}};
    end else begin
      pix_row = row_cnt;
      pix_col = col_cnt;
    end

    if (I_RGB_Vaild) begin
      raw_next = select_sample(pix_row[0] ^ PHASE[1], pix_col[0] ^ PHASE[0],
                               I_RGB_Data_r, I_RGB_Data_g, I_RGB_Data_b);
    end else begin
      raw_next = {DATA_WIDTH{1'b0}};
    end

    if (v_rise) begin
      row_next = {RW{1'b0}};
      col_next = I_RGB_Vaild ? CW'(1) : {CW{1'b0}};
    end else if (line_end) begin
      col_next = {CW{1'b0}};
      row_next = (row_cnt == ROW_MAX) ? row_cnt : row_cnt + RW'(1);
    end else if (I_RGB_Vaild) begin
      col_next = (col_cnt == COL_MAX) ? col_cnt : col_cnt + CW'(1);
      row_next = row_cnt;
    end else begin
      col_next = col_cnt;
      row_next = row_cnt;
    end

    // Line check uses the old column count even when V_Sync wins the update
    line_err_next  = line_end & (col_cnt != COL_LEN);
    frame_err_next = v_rise & (row_cnt != {RW{1'b0}}) & (row_cnt != ROW_LEN);
  end

  // State and registered outputs
  always_ff @(posedge I_Clk or posedge I_Rst) begin
    if (I_Rst) begin
      v_d         <= 1'b0;
      vaild_d     <= 1'b0;
      col_cnt     <= {CW{1'b0}};
      row_cnt     <= {RW{1'b0}};
      O_V_Sync    <= 1'b0;
      O_H_Sync    <= 1'b0;
      O_Raw_Vaild <= 1'b0;
      O_Raw_Data  <= {DATA_WIDTH{1'b0}};
      O_Line_Err  <= 1'b0;
      O_Frame_Err <= 1'b0;
    end else begin
      v_d         <= I_V_Sync;
      vaild_d     <= I_RGB_Vaild;
      col_cnt     <= col_next;
      row_cnt     <= row_next;
      O_V_Sync    <= I_V_Sync;
      O_H_Sync    <= I_H_Sync;
      O_Raw_Vaild <= I_RGB_Vaild;
      O_Raw_Data  <= raw_next;
      O_Line_Err  <= line_err_next;
      O_Frame_Err <= frame_err_next;
    end
  end

endmodule

// File: tb/tb_rgb2bayer_mosaic.sv
// Bench for rgb2bayer_mosaic: RGGB and BGGR instances share one stimulus stream and are
// checked every cycle against a position-tracking reference model.
module tb_rgb2bayer_mosaic;

  localparam int W    = 4;
  localparam int H    = 2;
  localparam int CMAX = (1 << $clog2(W + 1)) - 1;
  localparam int RMAX = (1 << $clog2(H + 1)) - 1;

  typedef struct packed {
    logic       v;
    logic       h;
    logic       val;
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
  } stim_t;

  logic       clk = 1'b0;
  logic       rst;
  logic       v, h, val;
  logic [7:0] r, g, b;
  logic       ov0, oh0, oval0, le0, fe0;
  logic       ov3, oh3, oval3, le3, fe3;
  logic [7:0] raw0, raw3;
  logic [12:0] act0, act3, exp0, exp3;

  int    m_row, m_col;
  logic  m_pv, m_pval;
  int    vec  = 0;
  int    miss = 0;
  stim_t sq[$];

  always #5 clk = ~clk;

  assign act0 = {ov0, oh0, oval0, raw0, le0, fe0};
  assign act3 = {ov3, oh3, oval3, raw3, le3, fe3};

  rgb2bayer_mosaic #(.DATA_WIDTH(8), .I_W(W), .I_H(H), .BAYER_PATTERN(0)) dut0 (
    .I_Clk(clk), .I_Rst(rst), .I_V_Sync(v), .I_H_Sync(h), .I_RGB_Vaild(val),
    .I_RGB_Data_r(r), .I_RGB_Data_g(g), .I_RGB_Data_b(b),
    .O_V_Sync(ov0), .O_H_Sync(oh0), .O_Raw_Vaild(oval0), .O_Raw_Data(raw0),
    .O_Line_Err(le0), .O_Frame_Err(fe0));

  rgb2bayer_mosaic #(.DATA_WIDTH(8), .I_W(W), .I_H(H), .BAYER_PATTERN(3)) dut3 (
    .I_Clk(clk), .I_Rst(rst), .I_V_Sync(v), .I_H_Sync(h), .I_RGB_Vaild(val),
    .I_RGB_Data_r(r), .I_RGB_Data_g(g), .I_RGB_Data_b(b),
    .O_V_Sync(ov3), .O_H_Sync(oh3), .O_Raw_Vaild(oval3), .O_Raw_Data(raw3),
    .O_Line_Err(le3), .O_Frame_Err(fe3));

  // CFA colour at an absolute (row, col) for a given phase: 0=RGGB 1=GRBG 2=GBRG 3=BGGR
  function automatic logic [7:0] model_raw(input int pat, input int row, input int col,
                                           input logic pv, input logic [7:0] pr,
                                           input logic [7:0] pg, input logic [7:0] pb);
    int rp;
    int cp;
    rp = (row + pat / 2) % 2;
    cp = (col + pat % 2) % 2;
    if (!pv) return 8'd0;
    if (rp == 0 && cp == 0) return pr;
    if (rp == 1 && cp == 1) return pb;
    return pg;
  endfunction

  function automatic void push(input logic pv, input logic ph, input logic pval,
                               input logic [7:0] pr, input logic [7:0] pg, input logic [7:0] pb);
    sq.push_back({pv, ph, pval, pr, pg, pb});
  endfunction

  function automatic void add_line(input int n, input int gap,
                                   input logic [7:0] pr, input logic [7:0] pg, input logic [7:0] pb);
    for (int i = 0; i < n; i++) push(1'b0, 1'b1, 1'b1, pr, pg, pb);
    for (int i = 0; i < gap; i++) push(1'b0, 1'b0, 1'b0, 8'd0, 8'd0, 8'd0);
  endfunction

  function automatic void add_vsync();
    push(1'b1, 1'b0, 1'b0, 8'd0, 8'd0, 8'd0);
    push(1'b0, 1'b0, 1'b0, 8'd0, 8'd0, 8'd0);
  endfunction

  // Apply one input cycle, predict the outputs it produces, advance the model
  task automatic drive(input stim_t s);
    logic vr, le;
    int   prow, pcol;
    @(negedge clk);
    v = s.v; h = s.h; val = s.val; r = s.r; g = s.g; b = s.b;
    vr   = s.v && !m_pv;
    le   = m_pval && !s.val;
    prow = vr ? 0 : m_row;
    pcol = vr ? 0 : m_col;
    exp0 = {s.v, s.h, s.val, model_raw(0, prow, pcol, s.val, s.r, s.g, s.b),
            le && (m_col != W), vr && (m_row != 0) && (m_row != H)};
    exp3 = {s.v, s.h, s.val, model_raw(3, prow, pcol, s.val, s.r, s.g, s.b),
            le && (m_col != W), vr && (m_row != 0) && (m_row != H)};
    if (vr) begin
      m_row = 0;
      m_col = s.val ? 1 : 0;
    end else if (le) begin
      m_col = 0;
      m_row = (m_row < RMAX) ? m_row + 1 : RMAX;
    end else if (s.val) begin
      m_col = (m_col < CMAX) ? m_col + 1 : CMAX;
    end
    m_pv   = s.v;
    m_pval = s.val;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    vec++;
    if (act0 !== 13'd0 || act3 !== 13'd0) begin
      miss++;
      $display("FAIL reset: got %h/%h required 0/0", act0, act3);
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_basic(input string nm);
    logic [7:0] got0[$];
    logic [7:0] got3[$];
    logic [7:0] e0[8];
    logic [7:0] e3[8];
    int errs;
    e0 = '{8'd10, 8'd20, 8'd10, 8'd20, 8'd20, 8'd30, 8'd20, 8'd30};
    e3 = '{8'd30, 8'd20, 8'd30, 8'd20, 8'd20, 8'd10, 8'd20, 8'd10};
    errs = 0;
    add_vsync();
    push(1'b0, 1'b0, 1'b0, 8'd0, 8'd0, 8'd0);
    add_line(4, 2, 8'd10, 8'd20, 8'd30);
    add_line(4, 2, 8'd10, 8'd20, 8'd30);
    add_vsync();
    foreach (sq[i]) begin
      drive(sq[i]);
      vec++;
      if (act0 !== exp0 || act3 !== exp3) begin
        miss++;
        $display("FAIL %s[%0d]: got %h/%h required %h/%h", nm, i, act0, act3, exp0, exp3);
      end
      if (oval0) got0.push_back(raw0);
      if (oval3) got3.push_back(raw3);
      errs += int'(le0) + int'(fe0) + int'(le3) + int'(fe3);
    end
    sq.delete();
    vec++;
    if (got0.size() != 8 || got3.size() != 8 || errs != 0) begin
      miss++;
      $display("FAIL %s_counts: got %0d/%0d samples %0d errs required 8/8 0",
               nm, got0.size(), got3.size(), errs);
    end else begin
      for (int k = 0; k < 8; k++) begin
        vec++;
        if (got0[k] !== e0[k] || got3[k] !== e3[k]) begin
          miss++;
          $display("FAIL %s_seq[%0d]: got %0d/%0d required %0d/%0d",
                   nm, k, got0[k], got3[k], e0[k], e3[k]);
        end
      end
    end
  endtask

  task automatic test_line_err();
    int n0, n3;
    n0 = 0; n3 = 0;
    add_line(3, 2, 8'd11, 8'd22, 8'd33);
    add_line(4, 2, 8'd44, 8'd55, 8'd66);
    foreach (sq[i]) begin
      drive(sq[i]);
      vec++;
      if (act0 !== exp0 || act3 !== exp3) begin
        miss++;
        $display("FAIL line_err[%0d]: got %h/%h required %h/%h", i, act0, act3, exp0, exp3);
      end
      n0 += int'(le0);
      n3 += int'(le3);
    end
    sq.delete();
    vec++;
    if (n0 != 1 || n3 != 1) begin
      miss++;
      $display("FAIL line_err_pulses: got %0d/%0d required 1/1", n0, n3);
    end
  endtask

  task automatic test_frame_err();
    int   nf;
    logic [7:0] first0;
    logic seen;
    nf = 0; seen = 1'b0; first0 = 8'd0;
    add_vsync();
    for (int k = 0; k < 3; k++) add_line(4, 1, 8'd1, 8'd2, 8'd3);
    add_vsync();
    add_line(4, 2, 8'd71, 8'd72, 8'd73);
    foreach (sq[i]) begin
      drive(sq[i]);
      vec++;
      if (act0 !== exp0 || act3 !== exp3) begin
        miss++;
        $display("FAIL frame_err[%0d]: got %h/%h required %h/%h", i, act0, act3, exp0, exp3);
      end
      nf += int'(fe0);
      if (oval0 && raw0 > 8'd70 && !seen) begin
        first0 = raw0;
        seen = 1'b1;
      end
    end
    sq.delete();
    vec++;
    if (nf != 1 || first0 !== 8'd71) begin
      miss++;
      $display("FAIL frame_err_pulse: got %0d pulses first %0d required 1 pulse first 71", nf, first0);
    end
  endtask

  task automatic test_vsync_pixel();
    add_vsync();
    push(1'b0, 1'b0, 1'b0, 8'd0, 8'd0, 8'd0);
    push(1'b1, 1'b1, 1'b1, 8'd77, 8'd88, 8'd99);
    push(1'b1, 1'b1, 1'b1, 8'd77, 8'd88, 8'd99);
    push(1'b0, 1'b0, 1'b0, 8'd0, 8'd0, 8'd0);
    foreach (sq[i]) begin
      drive(sq[i]);
      vec++;
      if (act0 !== exp0 || act3 !== exp3) begin
        miss++;
        $display("FAIL vsync_pixel[%0d]: got %h/%h required %h/%h", i, act0, act3, exp0, exp3);
      end
      if (i == 3) begin
        vec++;
        if (raw0 !== 8'd77 || raw3 !== 8'd99 || fe0 !== 1'b0) begin
          miss++;
          $display("FAIL vsync_pixel_first: got %0d/%0d fe %b required 77/99 fe 0", raw0, raw3, fe0);
        end
      end
    end
    sq.delete();
  endtask

  task automatic test_random();
    for (int i = 0; i < 800; i++) begin
      push(($urandom % 10) == 0, 1'($urandom), ($urandom % 4) != 0,
           8'($urandom), 8'($urandom), 8'($urandom));
    end
    foreach (sq[i]) begin
      drive(sq[i]);
      vec++;
      if (act0 !== exp0 || act3 !== exp3) begin
        miss++;
        $display("FAIL random[%0d]: got %h/%h required %h/%h", i, act0, act3, exp0, exp3);
      end
    end
    sq.delete();
  endtask

  task automatic test_async_reset();
    add_vsync();
    add_line(3, 0, 8'd5, 8'd6, 8'd7);
    foreach (sq[i]) begin
      drive(sq[i]);
      vec++;
      if (act0 !== exp0 || act3 !== exp3) begin
        miss++;
        $display("FAIL pre_reset[%0d]: got %h/%h required %h/%h", i, act0, act3, exp0, exp3);
      end
    end
    sq.delete();
    #2;
    rst = 1'b1;
    #1;
    vec++;
    if (act0 !== 13'd0 || act3 !== 13'd0) begin
      miss++;
      $display("FAIL async_reset: got %h/%h required 0/0", act0, act3);
    end
    m_row = 0; m_col = 0; m_pv = 1'b0; m_pval = 1'b0;
    @(negedge clk);
    v = 1'b0; h = 1'b0; val = 1'b0; r = 8'd0; g = 8'd0; b = 8'd0;
    @(negedge clk);
    rst = 1'b0;
    test_basic("post_reset");
  endtask

  initial begin
    rst = 1'b1;
    v = 1'b0; h = 1'b0; val = 1'b0; r = 8'd0; g = 8'd0; b = 8'd0;
    m_row = 0; m_col = 0; m_pv = 1'b0; m_pval = 1'b0;
    #12;
    test_reset();
    test_basic("basic");
    test_line_err();
    test_frame_err();
    test_vsync_pixel();
    test_random();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
    $finish;
  end

endmodule

// File: doc/rgb2bayer_mosaic.md
Name: rgb2bayer_mosaic

Overview:
- Streaming RGB-to-Bayer re-mosaicer: the inverse of bayer2rgb_3x3.
- Takes a full-colour pixel stream framed by V_Sync/H_Sync/Vaild and emits one raw Bayer sample per pixel, choosing R, G or B by row/column parity and the configured CFA phase.
- Sits in front of bayer2rgb_3x3 in loop-back and regression benches, and on the sensor-emulation path.
- Also checks line length and frame height, and reports mismatches with single-cycle error pulses.

Parameters:
- DATA_WIDTH, 8, bits per colour component and per raw sample.
- I_W, 1922, expected valid pixels per line.
- I_H, 1082, expected lines per frame.
- BAYER_PATTERN, 0, CFA phase of pixel (0,0): 0=RGGB, 1=GRBG, 2=GBRG, 3=BGGR.

Ports:
- I_Clk  in  1  clock; all logic on the rising edge.
- I_Rst  in  1  reset, asynchronous, active-high.
- I_V_Sync  in  1  frame sync; its rising edge starts a frame.
- I_H_Sync  in  1  line sync; pipelined only, not used for counting.
- I_RGB_Vaild  in  1  input pixel valid; high for a contiguous run per line.
- I_RGB_Data_r  in  DATA_WIDTH  red component.
- I_RGB_Data_g  in  DATA_WIDTH  green component.
- I_RGB_Data_b  in  DATA_WIDTH  blue component.
- O_V_Sync  out  1  I_V_Sync delayed 1 cycle.
- O_H_Sync  out  1  I_H_Sync delayed 1 cycle.
- O_Raw_Vaild  out  1  I_RGB_Vaild delayed 1 cycle.
- O_Raw_Data  out  DATA_WIDTH  selected Bayer sample; 0 when not valid.
- O_Line_Err  out  1  1-cycle pulse: the line just ended with a pixel count other than I_W.
- O_Frame_Err  out  1  1-cycle pulse: the previous frame's line count was neither 0 nor I_H.

Behaviour:
- Reset (async assert, sync release):
  - All outputs are 0.
  - col_cnt, row_cnt, v_d and vaild_d are 0.
  - Reset mid-frame drops the frame. Lines after release are counted from row 0 until the next V_Sync edge.
- Latency: exactly 1 cycle for every output, with no gaps or throttling. There is no backpressure.
- Edge detection uses 1-cycle delayed copies of I_V_Sync (v_d) and I_RGB_Vaild (vaild_d).
  - V_Sync rise: I_V_Sync & ~v_d.
  - Line end: vaild_d & ~I_RGB_Vaild.
- Counters:
  - col_cnt is $clog2(I_W+1) bits and row_cnt is $clog2(I_H+1) bits; both saturate at all-ones.
  - Each valid cycle uses the current (row_cnt, col_cnt), then increments col_cnt.
  - On line end: col_cnt clears, row_cnt increments.
- Parity and selection:
  - r = row_cnt[0] ^ BAYER_PATTERN[1]; c = col_cnt[0] ^ BAYER_PATTERN[0].
  - (r,c) = (0,0) selects R, (0,1) or (1,0) selects G, (1,1) selects B.
  - The selected component is registered into O_Raw_Data when I_RGB_Vaild = 1; otherwise O_Raw_Data is 0.
- V_Sync rise:
  - If row_cnt ≠ 0 and row_cnt ≠ I_H, O_Frame_Err pulses on the next cycle.
  - row_cnt and col_cnt clear.
  - A valid pixel on that same cycle is treated as position (0,0), so col_cnt becomes 1.
- Line end: if col_cnt ≠ I_W, O_Line_Err pulses on the next cycle, aligned with O_Raw_Vaild falling.
- Simultaneous V_Sync rise and line end: V_Sync wins.
  - Counters clear; row_cnt does not increment.
  - The line-length check still runs on the old col_cnt.
- A valid run spanning V_Sync high is mosaiced normally; sync levels are only delayed.
- Line gaps of any length (including 1 cycle) are legal. A one-cycle valid dropout therefore ends the line.

Test Plan:
- I_W=4, I_H=2, RGGB, r/g/b=10/20/30 constant, V_Sync pulse then 2 lines -> O_Raw_Data: line0 10,20,10,20; line1 20,30,20,30. Each O_Raw_Vaild run is 4 cycles, 1 cycle after input. No error pulses.
- Same stimulus with BAYER_PATTERN=3 (BGGR) -> line0 30,20,30,20; line1 20,10,20,10.
- Line of 3 valid pixels with I_W=4 -> one O_Line_Err pulse 1 cycle after valid falls. Next line starts at col 0 with row parity advanced.
- 3 lines then V_Sync rise with I_H=2 -> O_Frame_Err pulses 1 cycle after the edge. The next line restarts at row 0 (R first for RGGB).
- Assert I_Rst mid-line (async, between clock edges) -> all outputs 0 immediately. After release and a fresh V_Sync, output matches the first scenario exactly.
- V_Sync rising on the same cycle as a valid pixel -> that pixel is emitted as R (RGGB); no spurious O_Frame_Err if row_cnt was 0.
